versatile_fifo_sync_ctrl: RTL and testbench

Single-clock FIFO controller that sits directly upstream of, and drives, the block RAM's simple-dual-port configuration (one write port A, one registered read port B). It turns valid/ready streams into RAM write/read addresses and enables. It hides the RAM's one-cycle read latency with a two-entry output skid buffer, so the read side is first-word-fall-through at one word per clock.

---
 rtl/versatile_fifo_sync_ctrl_if.sv | 29 ++
 rtl/versatile_fifo_sync_ctrl.sv | 77 +++++++
 tb/tb_versatile_fifo_sync_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/versatile_fifo_sync_ctrl_if.sv
// Stream and RAM-port bundle for versatile_fifo_sync_ctrl.
// The slave side is the controller; the master side is the producer, consumer and RAM.
interface versatile_fifo_sync_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
);
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [ADDR_WIDTH-1:0] ram_adr_a;
    logic [DATA_WIDTH-1:0] ram_d_a;
    logic                  ram_we_a;
    logic [ADDR_WIDTH-1:0] ram_adr_b;
    logic [DATA_WIDTH-1:0] ram_q_b;
    logic [ADDR_WIDTH+1:0] count;

    modport master (
        output wr_data, wr_valid, rd_ready, ram_q_b,
        input  wr_ready, rd_data, rd_valid, ram_adr_a, ram_d_a, ram_we_a, ram_adr_b, count
    );

    modport slave (
        input  wr_data, wr_valid, rd_ready, ram_q_b,
        output wr_ready, rd_data, rd_valid, ram_adr_a, ram_d_a, ram_we_a, ram_adr_b, count
    );
endinterface

// File: rtl/versatile_fifo_sync_ctrl.sv
// Single-clock FIFO controller for a simple-dual-port RAM with a registered read port.
// A two-entry skid buffer hides the RAM read latency, giving first-word-fall-through output.
module versatile_fifo_sync_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    versatile_fifo_sync_ctrl_if.slave bus
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam int CW = ADDR_WIDTH + 2;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [PW-1:0]         wp;
    logic [PW-1:0]         rp;
    logic [PW-1:0]         occ;
    logic                  pend;
    logic [1:0]            sk_cnt;
    logic                  sk_hd;
    logic [DATA_WIDTH-1:0] sk_mem [2];

    logic       flush;
    logic       ram_full;
    logic       ram_empty;
    logic       push;
    logic       pop;
    logic       issue;
    logic [2:0] sk_next;

    assign flush     = rst || clear;
    assign occ       = wp - rp;
    assign ram_full  = (occ == DEPTH);
    assign ram_empty = (occ == '0);

    assign bus.wr_ready = !ram_full && !flush;
    assign push         = bus.wr_valid && bus.wr_ready;

    assign bus.rd_valid = (sk_cnt != 2'd0) && !flush;
    assign bus.rd_data  = sk_mem[sk_hd];
    assign pop          = bus.rd_valid && bus.rd_ready;

    // Skid occupancy once the in-flight word lands and this cycle's pop leaves.
    assign sk_next = {1'b0, sk_cnt} + {2'b00, pend} - {2'b00, pop};
    assign issue   = !ram_empty && (sk_next < 3'd2);

    assign bus.ram_adr_a = wp[ADDR_WIDTH-1:0];
    assign bus.ram_d_a   = bus.wr_data;
    assign bus.ram_we_a  = push;
    assign bus.ram_adr_b = rp[ADDR_WIDTH-1:0];

    assign bus.count = flush ? '0 : ({1'b0, occ} + CW'(pend) + CW'(sk_cnt));

    always_ff @(posedge clk) begin
        if (flush) begin
            wp     <= '0;
            rp     <= '0;
            pend   <= 1'b0;
            sk_cnt <= 2'd0;
            sk_hd  <= 1'b0;
        end else begin
            if (push)  wp <= wp + 1'b1;
            if (issue) rp <= rp + 1'b1;
            pend   <= issue;
            sk_cnt <= sk_next[1:0];
            if (pop)   sk_hd <= ~sk_hd;
        end
    end

    // Capture goes to the tail; a flush drops any word still returning from the RAM.
    always_ff @(posedge clk) begin
        if (pend && !flush) begin
            sk_mem[sk_hd ^ sk_cnt[0]] <= bus.ram_q_b;
        end
    end
endmodule

// File: tb/tb_versatile_fifo_sync_ctrl.sv
// Bench for versatile_fifo_sync_ctrl: behavioural RAM, word-level queue model and directed steps.
module tb_versatile_fifo_sync_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic clear;

    always #5 clk = ~clk;

    versatile_fifo_sync_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    versatile_fifo_sync_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_we_a) mem[bus.ram_adr_a] <= bus.ram_d_a;
        bus.ram_q_b <= mem[bus.ram_adr_b];
    end

    // Model: word queue plus how many words sit in RAM, in flight, and visible at the output.
    logic [DW-1:0] q[$];
    int n_ram = 0, n_fly = 0, n_skid = 0;

    int checks = 0, errors = 0, cyc = 0, n_acc = 0;
    int obs_count;
    logic obs_rv, obs_wrr;
    logic [DW-1:0] obs_rd;
    logic [DW-1:0] got[$];
    int got_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic e_wrr, e_rv, mpush, mpop, issue;
        int e_cnt;
        @(negedge clk);
        e_wrr = (n_ram < DEPTH) && !rst && !clear;
        e_rv  = (n_skid > 0) && !rst && !clear;
        e_cnt = (rst || clear) ? 0 : q.size();
        obs_count = int'(bus.count);
        obs_rv    = bus.rd_valid;
        obs_wrr   = bus.wr_ready;
        obs_rd    = bus.rd_data;
        chk("wr_ready", bus.wr_ready, e_wrr);
        chk("rd_valid", bus.rd_valid, e_rv);
        chk("count", bus.count, e_cnt);
        chk("ram_we_a", bus.ram_we_a, bus.wr_valid && e_wrr);
        if (e_rv) chk("rd_data", bus.rd_data, q[0]);
        mpush = bus.wr_valid && e_wrr;
        mpop  = e_rv && bus.rd_ready;
        if (bus.ram_we_a) n_acc++;
        if (mpop) begin
            got.push_back(bus.rd_data);
            got_cyc.push_back(cyc);
        end
        if (rst || clear) begin
            q.delete();
            n_ram = 0; n_fly = 0; n_skid = 0;
        end else begin
            issue = (n_ram > 0) && (n_skid + n_fly - int'(mpop) < 2);
            if (mpush) q.push_back(bus.wr_data);
            if (mpop) void'(q.pop_front());
            n_skid = n_skid + n_fly - int'(mpop);
            n_fly  = int'(issue);
            n_ram  = n_ram + int'(mpush) - int'(issue);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int exp_cs[5];
        int start;
        logic [DW-1:0] v;
        exp_cs = '{0, 1, 1, 1, 0};

        // Reset held two clocks with a write pending.
        rst = 1'b1; clear = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_data = 8'h55; bus.rd_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("rst_wr_ready", obs_wrr, 1'b0);
            chk("rst_count", obs_count, 0);
        end
        rst = 1'b0; bus.wr_valid = 1'b0;
        cycle();
        chk("wr_ready_after_rst", obs_wrr, 1'b1);

        // Single word latency.
        bus.rd_ready = 1'b1; bus.wr_valid = 1'b1; bus.wr_data = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            cycle();
            bus.wr_valid = 1'b0;
            chk("lat_count", obs_count, exp_cs[i]);
            if (i == 3) begin
                chk("lat_rd_valid", obs_rv, 1'b1);
                chk("lat_rd_data", obs_rd, 8'hA5);
            end
        end

        // Fill with the consumer stalled, then drain.
        bus.rd_ready = 1'b0; n_acc = 0;
        for (int i = 1; i <= 8; i++) begin
            bus.wr_valid = 1'b1; bus.wr_data = DW'(i);
            cycle();
        end
        bus.wr_valid = 1'b0;
        cycle(); cycle();
        chk("fill_accepted", n_acc, 6);
        chk("fill_count", obs_count, 6);
        chk("fill_wr_ready", obs_wrr, 1'b0);
        got.delete(); got_cyc.delete();
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        chk("drain_size", got.size(), 6);
        for (int k = 0; k < 6; k++) begin
            v = (k < got.size()) ? got[k] : 8'hFF;
            chk("drain_order", v, DW'(k + 1));
        end
        chk("drain_span", (got.size() == 6) ? got_cyc[5] - got_cyc[0] : -1, 5);
        chk("drain_empty", obs_rv, 1'b0);

        // Streaming across the pointer wrap.
        got.delete(); got_cyc.delete();
        start = cyc;
        for (int i = 0; i < 20; i++) begin
            bus.wr_valid = 1'b1; bus.wr_data = DW'(8'h40 + i);
            cycle();
        end
        bus.wr_valid = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("stream_size", got.size(), 20);
        for (int k = 0; k < 20; k++) begin
            v = (k < got.size()) ? got[k] : 8'hFF;
            chk("stream_order", v, DW'(8'h40 + k));
        end
        chk("stream_first", (got.size() == 20) ? got_cyc[0] - start : -1, 3);
        chk("stream_no_bubble", (got.size() == 20) ? got_cyc[19] - got_cyc[0] : -1, 19);

        // Random valid/ready; the model checks every cycle.
        for (int i = 0; i < 1000; i++) begin
            bus.wr_valid = 1'($urandom_range(0, 1));
            bus.rd_ready = 1'($urandom_range(0, 1));
            bus.wr_data  = DW'($urandom);
            cycle();
        end
        bus.wr_valid = 1'b0; bus.rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        chk("random_drained", obs_count, 0);

        // Clear with five words held and a read in flight.
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.wr_valid = 1'b1; bus.wr_data = DW'(8'h90 + i);
            cycle();
        end
        bus.wr_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        bus.rd_ready = 1'b1;
        cycle();
        bus.rd_ready = 1'b0;
        clear = 1'b1;
        cycle();
        chk("pre_clear_count", obs_count, 0);
        clear = 1'b0;
        cycle();
        chk("clear_count", obs_count, 0);
        chk("clear_rd_valid", obs_rv, 1'b0);
        cycle(); cycle();
        chk("clear_stale", obs_rv, 1'b0);
        got.delete(); got_cyc.delete();
        bus.rd_ready = 1'b1; bus.wr_valid = 1'b1; bus.wr_data = 8'h3C;
        cycle();
        bus.wr_valid = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("clear_next_size", got.size(), 1);
        v = (got.size() > 0) ? got[0] : 8'hFF;
        chk("clear_next_word", v, 8'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
